// File: rtl/ram_bank_pkg.sv
// Shared definitions for the even/odd interleaved RAM bank controller and
// the bank wrapper that sits behind it.
package ram_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    localparam int ROWS_PER_COL = 256;
    localparam int NUM_BANKS    = 2;
    localparam int WORD_BYTES   = 4;

    // Byte size of the interleaved window: two banks of 256*cols 32-bit words.
    function automatic logic [31:0] win_bytes(input int cols);
        return 32'(NUM_BANKS * WORD_BYTES * ROWS_PER_COL * cols);
    endfunction

endpackage

// File: rtl/ram_bank_ctrl_if.sv
// Wishbone classic slave bundle between a bus master and ram_bank_ctrl.
interface ram_bank_ctrl_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_err_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_err_o, wbs_dat_o
    );

endinterface

// File: rtl/ram_bank_ctrl.sv
// Wishbone slave front-end for two word-interleaved RAM banks (address bit 2
// picks even/odd); fixed 3-cycle transfer, out-of-window requests get err.
module ram_bank_ctrl
    import ram_bank_pkg::*;
#(
    parameter int          COLS = 4,
    parameter logic [31:0] BASE = 32'h3000_0000,
    localparam int         AW   = 8 + $clog2(COLS)
) (
    input  logic          CLK,
    input  logic          RST_N,
    ram_bank_ctrl_if.slave wbs,
    output logic          ev_EN,
    output logic          od_EN,
    output logic [3:0]    ev_WE,
    output logic [3:0]    od_WE,
    output logic [AW-1:0] ev_A,
    output logic [AW-1:0] od_A,
    output logic [31:0]   ev_Di,
    output logic [31:0]   od_Di,
    input  logic [31:0]   ev_Do,
    input  logic [31:0]   od_Do
);

    localparam logic [31:0] WIN = win_bytes(COLS);

    state_t        state, state_nx;
    logic          req;
    logic          in_win;
    logic          bsel;
    logic          bsel_q;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [AW-1:0] ev_a_q, od_a_q;
    logic [31:0]   ev_di_q, od_di_q;

    assign req    = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    // Offset compare wraps addresses below BASE to huge values, so one test
    // covers both ends of the window on the full 32-bit address.
    assign in_win = (wbs.wbs_adr_i - BASE) < WIN;
    assign bsel   = wbs.wbs_adr_i[2];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Each bank keeps its own A/Di so the idle bank never toggles.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bsel_q  <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            ev_a_q  <= '0;
            od_a_q  <= '0;
            ev_di_q <= '0;
            od_di_q <= '0;
        end else if (state == ST_IDLE && req && in_win) begin
            bsel_q <= bsel;
            we_q   <= wbs.wbs_we_i;
            sel_q  <= wbs.wbs_sel_i;
            if (bsel) begin
                od_a_q  <= wbs.wbs_adr_i[AW+2:3];
                od_di_q <= wbs.wbs_dat_i;
            end else begin
                ev_a_q  <= wbs.wbs_adr_i[AW+2:3];
                ev_di_q <= wbs.wbs_dat_i;
            end
        end
    end

    assign ev_A  = ev_a_q;
    assign od_A  = od_a_q;
    assign ev_Di = ev_di_q;
    assign od_Di = od_di_q;

    always_comb begin
        state_nx      = state;
        ev_EN         = 1'b0;
        od_EN         = 1'b0;
        ev_WE         = 4'h0;
        od_WE         = 4'h0;
        wbs.wbs_ack_o = 1'b0;
        wbs.wbs_err_o = 1'b0;
        wbs.wbs_dat_o = 32'h0;
        case (state)
            ST_IDLE: begin
                if (req) state_nx = in_win ? ST_ACCESS : ST_ERR;
            end
            // Enables are gated by live cyc so a master abort commits nothing.
            ST_ACCESS: begin
                if (wbs.wbs_cyc_i) begin
                    if (bsel_q) begin
                        od_EN = 1'b1;
                        od_WE = we_q ? sel_q : 4'h0;
                    end else begin
                        ev_EN = 1'b1;
                        ev_WE = we_q ? sel_q : 4'h0;
                    end
                    state_nx = ST_ACK;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ACK: begin
                wbs.wbs_ack_o = 1'b1;
                if (!we_q) wbs.wbs_dat_o = bsel_q ? od_Do : ev_Do;
                state_nx = ST_IDLE;
            end
            ST_ERR: begin
                wbs.wbs_err_o = 1'b1;
                state_nx      = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
